// File: rtl/mux_4_1_arbiter.sv
// Round-robin arbiter for four requesters sharing one output path.
// It drives the mux select and registers the selected word, and a burst limit keeps one owner from holding the path.
module mux_4_1_arbiter #(
  parameter int BITS_NUM  = 2,
  parameter int MAX_BURST = 4
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [3:0]          REQ,
  input  logic [BITS_NUM-1:0] A,
  input  logic [BITS_NUM-1:0] B,
  input  logic [BITS_NUM-1:0] C,
  input  logic [BITS_NUM-1:0] D,
  output logic [3:0]          GNT,
  output logic [1:0]          SEL,
  output logic [BITS_NUM-1:0] Q,
  output logic                Q_VALID,
  output logic                BUSY
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;
  localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);

  logic [0:0]          state, nxt_state;
  logic [1:0]          ptr, nxt_ptr;
  logic [7:0]          cnt, nxt_cnt, cnt_inc;
  logic [1:0]          nxt_sel;
  logic [3:0]          nxt_gnt;
  logic [3:0]          others;
  logic [2:0]          pick_idle, pick_next;
  logic                xfer;
  logic [BITS_NUM-1:0] mux_word;

  // Returns {found, index}; the lowest offset from start wins, so scan from the far end.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

  always_comb begin
    xfer      = (state == ST_OWN) && REQ[SEL];
    others    = REQ & ~onehot(SEL);
    pick_idle = rr_pick(REQ, ptr);
    pick_next = rr_pick(others, SEL + 2'd1);
    cnt_inc   = cnt + 8'd1;

    nxt_state = state;
    nxt_sel   = SEL;
    nxt_gnt   = GNT;
    nxt_ptr   = ptr;
    nxt_cnt   = cnt;

    case (state)
      ST_IDLE: begin
        if (|REQ) begin
          nxt_state = ST_OWN;
          nxt_sel   = pick_idle[1:0];
          nxt_gnt   = onehot(pick_idle[1:0]);
          nxt_ptr   = pick_idle[1:0] + 2'd1;
          nxt_cnt   = 8'd0;
        end
      end
      default: begin
        if (!xfer) begin
          nxt_cnt = 8'd0;
          if (pick_next[2]) begin
            nxt_sel = pick_next[1:0];
            nxt_gnt = onehot(pick_next[1:0]);
            nxt_ptr = pick_next[1:0] + 2'd1;
          end else begin
            nxt_state = ST_IDLE;
            nxt_gnt   = 4'b0000;
          end
        end else if (cnt_inc == BURST_LIM) begin
          // Burst exhausted: hand over if anyone else waits, otherwise keep streaming.
          nxt_cnt = 8'd0;
          if (pick_next[2]) begin
            nxt_sel = pick_next[1:0];
            nxt_gnt = onehot(pick_next[1:0]);
            nxt_ptr = pick_next[1:0] + 2'd1;
          end
        end else begin
          nxt_cnt = cnt_inc;
        end
      end
    endcase
  end

  always_comb begin
    case (SEL)
      2'd0:    mux_word = A;
      2'd1:    mux_word = B;
      2'd2:    mux_word = C;
      default: mux_word = D;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= ST_IDLE;
      SEL     <= 2'd0;
      GNT     <= 4'b0000;
      ptr     <= 2'd0;
      cnt     <= 8'd0;
      Q       <= '0;
      Q_VALID <= 1'b0;
    end else begin
      state   <= nxt_state;
      SEL     <= nxt_sel;
      GNT     <= nxt_gnt;
      ptr     <= nxt_ptr;
      cnt     <= nxt_cnt;
      Q_VALID <= xfer;
      if (xfer) Q <= mux_word;
    end
  end

  assign BUSY = (state == ST_OWN);

endmodule

// File: tb/tb_mux_4_1_arbiter.sv
// Directed bench for mux_4_1_arbiter: per-cycle vector table plus an asynchronous mid-burst reset sequence.
module tb_mux_4_1_arbiter;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [3:0] REQ = 4'b0000;
  logic [1:0] A = 2'd0, B = 2'd0, C = 2'd0, D = 2'd0;
  logic [3:0] GNT;
  logic [1:0] SEL;
  logic [1:0] Q;
  logic       Q_VALID;
  logic       BUSY;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  mux_4_1_arbiter #(.BITS_NUM(2), .MAX_BURST(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ),
    .A(A), .B(B), .C(C), .D(D),
    .GNT(GNT), .SEL(SEL), .Q(Q), .Q_VALID(Q_VALID), .BUSY(BUSY)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [1:0] a, b, c, d;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [1:0] q;
    logic       qv;
    logic       busy;
    int         rep;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic [3:0] req, input logic [1:0] a, b, c, d,
                     input logic [3:0] gnt, input logic [1:0] sel, input logic [1:0] q,
                     input logic qv, input logic busy, input int rep);
    vec_t v;
    v = '{rst, req, a, b, c, d, gnt, sel, q, qv, busy, rep};
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    REQ = 4'b0000;
    RST_N = 1'b0;
    #12;
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    // Full contention, A=3 B=2 C=1 D=0, MAX_BURST=4
    add(1, 4'b1111, 3, 2, 1, 0, 4'b0001, 0, 0, 0, 1, 1);
    add(0, 4'b1111, 3, 2, 1, 0, 4'b0001, 0, 3, 1, 1, 3);
    add(0, 4'b1111, 3, 2, 1, 0, 4'b0010, 1, 3, 1, 1, 1);
    add(0, 4'b1111, 3, 2, 1, 0, 4'b0010, 1, 2, 1, 1, 3);
    add(0, 4'b1111, 3, 2, 1, 0, 4'b0100, 2, 2, 1, 1, 1);
    add(0, 4'b1111, 3, 2, 1, 0, 4'b0100, 2, 1, 1, 1, 3);
    add(0, 4'b1111, 3, 2, 1, 0, 4'b1000, 3, 1, 1, 1, 1);
    add(0, 4'b1111, 3, 2, 1, 0, 4'b1000, 3, 0, 1, 1, 3);
    add(0, 4'b1111, 3, 2, 1, 0, 4'b0001, 0, 0, 1, 1, 1);
    add(0, 4'b1111, 3, 2, 1, 0, 4'b0001, 0, 3, 1, 1, 1);
    // Single requester streams across burst rollover
    add(1, 4'b0001, 3, 0, 0, 0, 4'b0001, 0, 0, 0, 1, 1);
    add(0, 4'b0001, 3, 0, 0, 0, 4'b0001, 0, 3, 1, 1, 12);
    // B owns, releases after 2 transfers while C waits, then C releases to idle
    add(1, 4'b0110, 3, 2, 1, 0, 4'b0010, 1, 0, 0, 1, 1);
    add(0, 4'b0110, 3, 2, 1, 0, 4'b0010, 1, 2, 1, 1, 2);
    add(0, 4'b0100, 3, 2, 1, 0, 4'b0100, 2, 2, 0, 1, 1);
    add(0, 4'b0100, 3, 2, 1, 0, 4'b0100, 2, 1, 1, 1, 1);
    add(0, 4'b0000, 3, 2, 1, 0, 4'b0000, 2, 1, 0, 0, 2);
    // D owns with REQ=1001, hands to A after 4 transfers; PTR=1 then grants B from idle
    add(1, 4'b1000, 3, 2, 1, 0, 4'b1000, 3, 0, 0, 1, 1);
    add(0, 4'b1001, 3, 2, 1, 0, 4'b1000, 3, 0, 1, 1, 3);
    add(0, 4'b1001, 3, 2, 1, 0, 4'b0001, 0, 0, 1, 1, 1);
    add(0, 4'b1001, 3, 2, 1, 0, 4'b0001, 0, 3, 1, 1, 1);
    add(0, 4'b0000, 3, 2, 1, 0, 4'b0000, 0, 3, 0, 0, 1);
    add(0, 4'b1111, 3, 2, 1, 0, 4'b0010, 1, 3, 0, 1, 1);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      for (int r = 0; r < tbl[i].rep; r++) begin
        @(negedge CLK);
        REQ = tbl[i].req;
        A = tbl[i].a; B = tbl[i].b; C = tbl[i].c; D = tbl[i].d;
        @(posedge CLK);
        #1;
        check($sformatf("v%0d.%0d gnt", i, r), GNT, tbl[i].gnt);
        check($sformatf("v%0d.%0d sel", i, r), {2'b00, SEL}, {2'b00, tbl[i].sel});
        check($sformatf("v%0d.%0d q_valid", i, r), {3'b000, Q_VALID}, {3'b000, tbl[i].qv});
        check($sformatf("v%0d.%0d busy", i, r), {3'b000, BUSY}, {3'b000, tbl[i].busy});
        if (tbl[i].qv || i > 0) check($sformatf("v%0d.%0d q", i, r), {2'b00, Q}, {2'b00, tbl[i].q});
        check($sformatf("v%0d.%0d gnt_onehot0", i, r), {3'b000, $onehot0(GNT)}, 4'b0001);
      end
    end

    // Asynchronous reset mid-burst
    do_reset();
    @(negedge CLK);
    REQ = 4'b1111; A = 2'd3; B = 2'd2; C = 2'd1; D = 2'd0;
    repeat (3) @(posedge CLK);
    #1;
    check("pre_rst q", {2'b00, Q}, 4'd3);
    check("pre_rst gnt", GNT, 4'b0001);
    #2;
    RST_N = 1'b0;
    #1;
    check("async_rst gnt", GNT, 4'b0000);
    check("async_rst sel", {2'b00, SEL}, 4'd0);
    check("async_rst q", {2'b00, Q}, 4'd0);
    check("async_rst q_valid", {3'b000, Q_VALID}, 4'd0);
    check("async_rst busy", {3'b000, BUSY}, 4'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    check("post_rst gnt", GNT, 4'b0001);
    check("post_rst sel", {2'b00, SEL}, 4'd0);
    check("post_rst busy", {3'b000, BUSY}, 4'd1);
    @(posedge CLK);
    #1;
    check("post_rst q", {2'b00, Q}, 4'd3);
    check("post_rst q_valid", {3'b000, Q_VALID}, 4'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
